// File: rtl/tick_pkg.sv
// Shared constants and types for the multi-channel tick generator.
// Legacy divisors assume a 100 MHz system clock.
package tick_pkg;

  localparam logic MODE_TICK = 1'b0;
  localparam logic MODE_WAVE = 1'b1;

  localparam int unsigned DEF_CNT_W = 27;

  localparam logic [DEF_CNT_W-1:0] DIV_1HZ   = 27'd100_000_000;
  localparam logic [DEF_CNT_W-1:0] DIV_2HZ   = 27'd50_000_000;
  localparam logic [DEF_CNT_W-1:0] DIV_200HZ = 27'd500_000;
  localparam logic [DEF_CNT_W-1:0] DIV_BLINK = 27'd33_333_333;

  typedef enum logic [0:0] {StIdle, StRun} chan_state_e;

endpackage

// File: rtl/tick_gen_multi_if.sv
// Config, enable, sync and output bundle of tick_gen_multi.
// master drives config/enable/sync; slave is the generator.
interface tick_gen_multi_if import tick_pkg::*; #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = DEF_CNT_W
);
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_mode;
  logic [NCH-1:0]   en;
  logic             sync;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   wave;
  logic [NCH-1:0]   busy;

  modport master (
    output cfg_we, cfg_ch, cfg_div, cfg_mode, en, sync,
    input  tick, wave, busy
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, cfg_mode, en, sync,
    output tick, wave, busy
  );

endinterface

// File: rtl/tick_chan.sv
// One divider channel: counter, shadow/active divisor, mode and IDLE/RUN FSM.
// Divisor updates take effect only on a period boundary, idle, or sync.
module tick_chan import tick_pkg::*; #(
  parameter int unsigned      CNT_W    = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DEF_DIV  = CNT_W'(1),
  parameter logic             DEF_MODE = MODE_TICK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic             sync_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             mode_i,
  output logic             tick_o,
  output logic             wave_o,
  output logic             busy_o
);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] div_sh_q, div_sh_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             wave_q, wave_d;
  logic             run_ok;
  logic             term;

  always_comb begin
    run_ok    = en_i && (div_act_q != '0);
    term      = run_ok && step_i && !sync_i && (count_q == div_act_q - CNT_W'(1));
    // A write in this cycle is visible to this cycle's boundary (bypass).
    div_sh_d  = we_i ? div_i : div_sh_q;
    mode_d    = we_i ? mode_i : mode_q;
    div_act_d = div_act_q;
    count_d   = count_q;
    state_d   = state_q;
    tick_d    = term && (mode_d == MODE_TICK);
    wave_d    = wave_q;

    case (state_q)
      StIdle:  if (run_ok) state_d = StRun;
      StRun:   if (!run_ok) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (!run_ok || sync_i || term) begin
      count_d   = '0;
      div_act_d = div_sh_d;
    end else if (step_i) begin
      count_d = count_q + CNT_W'(1);
    end

    if (sync_i) begin
      wave_d = 1'b0;
    end else if (mode_q == MODE_WAVE && mode_d == MODE_TICK) begin
      wave_d = 1'b0;
    end else if (term && mode_d == MODE_WAVE) begin
      wave_d = ~wave_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      div_sh_q  <= DEF_DIV;
      div_act_q <= DEF_DIV;
      mode_q    <= DEF_MODE;
      tick_q    <= 1'b0;
      wave_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      div_sh_q  <= div_sh_d;
      div_act_q <= div_act_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      wave_q    <= wave_d;
    end
  end

  assign tick_o = tick_q;
  assign wave_o = wave_q;
  assign busy_o = (state_q == StRun);

endmodule

// File: rtl/tick_gen_multi.sv
// NCH-channel programmable tick / square-wave generator on one system clock.
// Define TICK_PRESCALE_EN to add a shared PRE_DIV prescaler ahead of all channels.
module tick_gen_multi import tick_pkg::*; #(
  parameter int unsigned          NCH      = 4,
  parameter int unsigned          CNT_W    = DEF_CNT_W,
  parameter logic [NCH*CNT_W-1:0] DEF_DIV  = {DIV_BLINK, DIV_200HZ, DIV_2HZ, DIV_1HZ},
  parameter logic [NCH-1:0]       DEF_EN   = {NCH{1'b1}},
  parameter logic [NCH-1:0]       DEF_MODE = '0
`ifdef TICK_PRESCALE_EN
  ,
  parameter int unsigned          PRE_DIV  = 100
`endif
) (
  input  logic             clk,
  input  logic             rst,
  tick_gen_multi_if.slave  bus
);

  logic [NCH-1:0] en_mask_q;
  logic [NCH-1:0] en_eff;
  logic [NCH-1:0] we_vec;
  logic [NCH-1:0] tick_vec;
  logic [NCH-1:0] wave_vec;
  logic [NCH-1:0] busy_vec;
  logic           step;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_mask_q <= DEF_EN;
    end
  end

  assign en_eff = bus.en & en_mask_q;

`ifdef TICK_PRESCALE_EN
  localparam int unsigned PRE_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

  logic [PRE_W-1:0] pre_q;
  logic             pre_tc;

  assign pre_tc = (pre_q == PRE_W'(PRE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || bus.sync || pre_tc) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  assign step = pre_tc;
`else
  assign step = 1'b1;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    // Out-of-range channel numbers simply match no channel.
    assign we_vec[k] = bus.cfg_we && (int'(bus.cfg_ch) == k);

    tick_chan #(
      .CNT_W    (CNT_W),
      .DEF_DIV  (DEF_DIV[k*CNT_W +: CNT_W]),
      .DEF_MODE (DEF_MODE[k])
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .step_i (step),
      .sync_i (bus.sync),
      .en_i   (en_eff[k]),
      .we_i   (we_vec[k]),
      .div_i  (bus.cfg_div),
      .mode_i (bus.cfg_mode),
      .tick_o (tick_vec[k]),
      .wave_o (wave_vec[k]),
      .busy_o (busy_vec[k])
    );
  end

  assign bus.tick = tick_vec;
  assign bus.wave = wave_vec;
  assign bus.busy = busy_vec;

endmodule

// File: doc/tick_gen_multi.md
Name: tick_gen_multi

Overview:
- Parametrised successor of the fixed four-output tick divider.
- NCH independent channels, each with a runtime-programmable divisor, an enable bit and an output mode (single-cycle tick or 50% square wave).
- Provides a global phase-align strobe.
- Feeds the display scan, debounce, blink and timekeeping logic from one configurable source on the single system clock.

Parameters:
- NCH, 4, number of channels (1..16).
- CNT_W, 27, counter and divisor width in bits; must hold the largest divisor.
- DEF_DIV, {33_333_333, 500_000, 50_000_000, 100_000_000}, reset divisors. Packed NCH*CNT_W vector; channel 0 is in the LSBs.
- DEF_EN, 4'b1111, per-channel enable after reset.
- DEF_MODE, 4'b0000, per-channel mode after reset; 0 = tick, 1 = square wave.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  config write strobe; one write per cycle.
- cfg_ch  in  $clog2(NCH) (min 1)  target channel of the write.
- cfg_div  in  CNT_W  new divisor for cfg_ch.
- cfg_mode  in  1  new mode for cfg_ch.
- en  in  NCH  per-channel run enable; level, sampled every cycle; ANDed with the reset-loaded DEF_EN mask register.
- sync  in  1  phase-align strobe: all counters restart together.
- tick  out  NCH  one-cycle pulse per period, for mode-0 channels.
- wave  out  NCH  square wave, toggles once per period, for mode-1 channels.
- busy  out  NCH  channel is running (enabled and divisor >= 1).

Behaviour:
- Reset: all counters 0; divisor registers = DEF_DIV; mode registers = DEF_MODE; enable mask = DEF_EN. tick, wave and busy are all 0 during the reset cycle. First tick on channel k occurs exactly div_k cycles after rst deasserts (same as the legacy divider).
- Per-channel state machine:
  - IDLE: entered when div == 0 or the enable is low. Counter held at 0; tick = 0; wave holds its last value; busy = 0.
  - RUN: entered when the enable is high and div >= 1. busy = 1.
  - IDLE -> RUN starts with count = 0.
- Counting in RUN:
  - count increments each cycle.
  - When count == div-1: count <= 0 and a terminal event fires.
    - mode 0: tick pulses high for the next cycle (registered, latency 1).
    - mode 1: wave toggles.
  - div == 1 in mode 0: tick is high every cycle while in RUN.
- Divisor write (cfg_we):
  - Written to a shadow register.
  - Shadow copies to the active divisor at the channel's next terminal event. No partial or short periods.
  - If the channel is IDLE, the copy is immediate.
  - Write in the same cycle as a terminal event: the newly written value becomes active at that event (write bypass).
  - Mode changes apply immediately. On a 1 -> 0 mode change, wave clears to 0.
- Enable drop mid-count: counter cleared; no tick is emitted.
- sync:
  - All RUN counters clear to 0 and all wave bits clear to 0.
  - No terminal event fires in the sync cycle, even if count == div-1.
  - sync together with cfg_we: the write is applied; the new divisor counts from 0 starting next cycle.
- cfg_ch >= NCH: write ignored.
- Arithmetic: unsigned CNT_W-bit; counter never exceeds div-1, so no wrap-around is possible.
- rst has priority over sync; sync has priority over counting.

Optional Feature:
- Macro: TICK_PRESCALE_EN.
- When defined:
  - Adds parameter PRE_DIV (default 100) and a shared prescaler counter.
  - Channel counters advance only on prescaler terminal cycles. Effective period = div*PRE_DIV, which allows a smaller CNT_W.
  - sync and rst also clear the prescaler.
  - tick remains exactly one clk cycle wide.
- When undefined: channels count every clk cycle; no prescaler logic exists.

Decomposition:
- Package tick_pkg: mode constants MODE_TICK = 0 and MODE_WAVE = 1; default CNT_W; legacy divisor constants (100 MHz -> 1 Hz, 2 Hz, 200 Hz, blink).
- Sub-module tick_chan: one channel holding counter, shadow/active divisor, mode and the IDLE/RUN state machine. The top instantiates NCH copies via generate and owns config decode, enable mask, sync fan-out and the optional prescaler.

Test Plan:
- Reset then run with DEF_DIV overridden to {4,3,2,1}: tick[0] high every cycle; tick[1] every 2nd; tick[2] every 3rd; tick[3] every 4th. First pulses at cycles 1, 2, 3, 4 after rst deassertion.
- Channel 1 running div = 5: write cfg_div = 3 mid-period. The current 5-cycle period completes, then 3-cycle periods follow. A write landing exactly on a terminal event makes the next period 3.
- Channel 2 in mode 1 with div = 4: wave toggles every 4 cycles (8-cycle period, 50% duty). Switch to mode 0: wave clears to 0 and tick pulses every 4 cycles.
- Channel 0 with div = 10: assert sync at count = 6. No tick occurs; the next tick is 10 cycles later. Two channels with div = 10 are phase-aligned after sync.
- Write cfg_div = 0 to channel 3: busy[3] = 0 and no ticks. Write div = 2 while IDLE: busy returns 1 and ticks start every 2 cycles. Drop en[3] mid-count: no tick is emitted. Write with cfg_ch = NCH: no channel changes.
- With TICK_PRESCALE_EN, PRE_DIV = 3, div = 2: tick every 6 cycles, each pulse 1 cycle wide. rst asserted mid-count returns all outputs to 0 on the next edge.
